dm_store_buffer: RTL and testbench
==================================

// Module: dm_store_buffer
// PURPOSE
//   Word-granular FIFO store buffer between the MEM-stage store path and the data memory write port.
//   Accepts one store per cycle from the pipeline and drains one store per cycle into DM
//   (dm_write/dm_addr/dm_wdata). Loads search it by word address; on a hit the MEM stage uses
//   ld_fwd_data instead of the DM read data.
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   ADDR_W  32  byte-address width
//   DATA_W  32  store data width (one word)
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       asynchronous, active-high; clears all state
//   st_valid     in   1       store request from MEM stage
//   st_addr      in   ADDR_W  store byte address; [1:0] ignored
//   st_data      in   DATA_W  store word
//   st_ready     out  1       buffer can accept a store this cycle
//   ld_addr      in   ADDR_W  load byte address to search; [1:0] ignored
//   ld_hit       out  1       a buffered entry matches ld_addr[ADDR_W-1:2]
//   ld_fwd_data  out  DATA_W  data of the youngest matching entry; 0 when !ld_hit
//   dm_write     out  1       head entry valid, write request to DM
//   dm_addr      out  ADDR_W  head address, [1:0] forced to 2'b00
//   dm_wdata     out  DATA_W  head data
//   dm_ready     in   1       DM accepts the write on this edge
//   empty        out  1       no valid entries (used to hold syscall/eret until drained)
// BEHAVIOUR
//   - State: entry regs addr[ADDR_W-1:2]/data/valid, head ptr, tail ptr, count ($clog2(DEPTH+1) bits).
//   - Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0).
//   - Reset (async): count, head, tail, all valid = 0 -> dm_write=0, empty=1, ld_hit=0,
//     ld_fwd_data=0, st_ready=1. Reset mid-operation discards pending stores; nothing reaches DM.
//   - Push: st_valid && st_ready at posedge writes entry[tail], tail++, count++.
//   - st_ready = !full, computed from registered count only; no push-through on a same-cycle pop.
//     st_valid while !st_ready is ignored; the stage above must stall.
//   - Drain: dm_write = !empty, driven combinationally from entry[head].
//     On dm_write && dm_ready: clear entry[head].valid, head++, count--.
//   - Latency: a store accepted at edge N is presented on dm_write after edge N,
//     earliest DM write at edge N+1 when the buffer was empty.
//   - Simultaneous push and pop: both take effect and count is unchanged. Allowed when empty: pop needs valid head,
//     so only the push happens.
//   - Forwarding (combinational): compare ld_addr[ADDR_W-1:2] with every valid entry.
//     Priority goes to the youngest entry in age order from tail-1 back to head.
//     A store pushed on this edge is not visible until the next cycle.
//     An entry being popped this cycle still forwards.
//   - DM ordering: stores reach DM in program order; DM sees every store exactly once.
// CONFIGURATION
//   DM_STORE_BUFFER_COALESCE_EN
//   - Defined: a push whose word address equals the youngest valid entry (tail-1) overwrites that
//     entry's data in place. No allocation; count, tail unchanged. Coalescing is allowed when full (st_ready
//     still = !full, so the stage stalls). It is suppressed when that entry is the head being popped this cycle, and
//     suppressed when empty; the push then allocates normally.
//   - Undefined: every accepted store allocates a new entry.
// TESTING
//   1 reset mid-run with 3 entries, dm_ready=0 -> async: empty=1, dm_write=0, st_ready=1; no DM write ever
//     issued for the discarded entries.
//   2 push A=0x10/0x11111111, dm_ready=0 -> next cycle dm_write=1, dm_addr=0x10, dm_wdata=0x11111111;
//     dm_ready=1 one cycle -> empty=1.
//   3 dm_ready=0, push 4 stores 0x0,0x4,0x8,0xC -> st_ready=0; 5th st_valid ignored; then dm_ready=1 ->
//     DM sees 0x0,0x4,0x8,0xC in order, one per cycle.
//   4 push 0x20/0xAAAA then 0x20/0xBBBB (macro off), ld_addr=0x22 -> ld_hit=1, ld_fwd_data=0xBBBB;
//     ld_addr=0x24 -> ld_hit=0, ld_fwd_data=0.
//   5 full buffer: push + pop same cycle -> push ignored (st_ready=0), count=3;
//     count=2 push+pop -> count stays 2.
//   6 DM_STORE_BUFFER_COALESCE_EN, dm_ready=0: push 0x30/0x1, then 0x30/0x2 -> count=1; drain writes 0x30/0x2 once.

Source files
------------

// File: rtl/dm_store_buffer.sv
// Word-granular FIFO store buffer between the MEM-stage store path and the data memory write port.
// Optional in-place coalescing of back-to-back stores to the same word: DM_STORE_BUFFER_COALESCE_EN.
module dm_store_buffer #(
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = 32,
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             st_valid_i,
  input  logic [AddrW-1:0] st_addr_i,
  input  logic [DataW-1:0] st_data_i,
  output logic             st_ready_o,
  input  logic [AddrW-1:0] ld_addr_i,
  output logic             ld_hit_o,
  output logic [DataW-1:0] ld_fwd_data_o,
  output logic             dm_write_o,
  output logic [AddrW-1:0] dm_addr_o,
  output logic [DataW-1:0] dm_wdata_o,
  input  logic             dm_ready_i,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned WordW = AddrW - 2;

  logic [WordW-1:0] addr_q [Depth];
  logic [WordW-1:0] addr_d [Depth];
  logic [DataW-1:0] data_q [Depth];
  logic [DataW-1:0] data_d [Depth];
  logic [Depth-1:0] valid_q, valid_d;
  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic             full, pop, push_alloc, coalesce;
  logic [WordW-1:0] st_word, ld_word;

  assign st_word    = st_addr_i[AddrW-1:2];
  assign ld_word    = ld_addr_i[AddrW-1:2];
  assign full       = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign st_ready_o = !full;
  assign pop        = !empty_o && dm_ready_i;

`ifdef DM_STORE_BUFFER_COALESCE_EN
  logic [PtrW-1:0] youngest;
  assign youngest = tail_q - PtrW'(1);
  // Merging into the head while it drains would lose the new data, so allocate instead.
  assign coalesce = st_valid_i && !empty_o && valid_q[youngest] &&
                    (addr_q[youngest] == st_word) && !(pop && (youngest == head_q));
`else
  assign coalesce = 1'b0;
`endif

  assign push_alloc = st_valid_i && !full && !coalesce;

  assign dm_write_o = !empty_o;
  assign dm_addr_o  = {addr_q[head_q], 2'b00};
  assign dm_wdata_o = data_q[head_q];

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    ld_hit_o      = 1'b0;
    ld_fwd_data_o = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      idx = head_q + PtrW'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_word)) begin
        ld_hit_o      = 1'b1;
        ld_fwd_data_o = data_q[idx];
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CntW'(push_alloc) - CntW'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrW'(1);
    end
    if (push_alloc) begin
      addr_d[tail_q]  = st_word;
      data_d[tail_q]  = st_data_i;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PtrW'(1);
    end
    if (coalesce) begin
      data_d[tail_q - PtrW'(1)] = st_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer; DM writes are logged by a monitor.
module tb_dm_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        st_ready, ld_hit, dm_write, dm_ready, empty;
  logic [31:0] ld_fwd_data, dm_addr, dm_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  dm_store_buffer #(.Depth(4), .AddrW(32), .DataW(32)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .st_valid_i   (st_valid),
    .st_addr_i    (st_addr),
    .st_data_i    (st_data),
    .st_ready_o   (st_ready),
    .ld_addr_i    (ld_addr),
    .ld_hit_o     (ld_hit),
    .ld_fwd_data_o(ld_fwd_data),
    .dm_write_o   (dm_write),
    .dm_addr_o    (dm_addr),
    .dm_wdata_o   (dm_wdata),
    .dm_ready_i   (dm_ready),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_write && dm_ready) begin
      wr_addr.push_back(dm_addr);
      wr_data.push_back(dm_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_addr = '0; dm_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check_eq("rst_empty", 32'(empty), 1);
    check_eq("rst_dm_write", 32'(dm_write), 0);
    check_eq("rst_st_ready", 32'(st_ready), 1);
    check_eq("rst_ld_hit", 32'(ld_hit), 0);
    check_eq("rst_ld_fwd", ld_fwd_data, 0);

    // 1: async reset discards pending stores
    push(32'h100, 32'h1); push(32'h104, 32'h2); push(32'h108, 32'h3);
    check_eq("t1_pre_empty", 32'(empty), 0);
    #2 reset = 1'b1;
    #1;
    check_eq("t1_async_empty", 32'(empty), 1);
    check_eq("t1_async_dm_write", 32'(dm_write), 0);
    check_eq("t1_async_st_ready", 32'(st_ready), 1);
    tick();
    reset = 1'b0;
    dm_ready = 1'b1;
    repeat (3) tick();
    check_eq("t1_no_dm_writes", 32'(wr_addr.size()), 0);
    dm_ready = 1'b0;

    // 2: single store latency and drain
    clear_log();
    push(32'h10, 32'h11111111);
    check_eq("t2_dm_write", 32'(dm_write), 1);
    check_eq("t2_dm_addr", dm_addr, 32'h10);
    check_eq("t2_dm_wdata", dm_wdata, 32'h11111111);
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    check_eq("t2_empty", 32'(empty), 1);
    check_eq("t2_writes", 32'(wr_addr.size()), 1);
    if (wr_addr.size() == 1) check_eq("t2_wr_addr", wr_addr[0], 32'h10);

    // 3: fill, overflow attempt ignored, in-order drain
    clear_log();
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'hA0 + 32'(i));
    check_eq("t3_full_st_ready", 32'(st_ready), 0);
    push(32'h40, 32'hDEAD);
    check_eq("t3_still_full", 32'(st_ready), 0);
    dm_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("t3_rate%0d", i), 32'(wr_addr.size()), 32'(i + 1));
    end
    dm_ready = 1'b0;
    check_eq("t3_empty", 32'(empty), 1);
    for (int i = 0; i < 4; i++) begin
      if (wr_addr.size() > i) begin
        check_eq($sformatf("t3_addr%0d", i), wr_addr[i], 32'(i * 4));
        check_eq($sformatf("t3_data%0d", i), wr_data[i], 32'hA0 + 32'(i));
      end
    end

    // 4: forwarding priority and miss
    clear_log();
    st_valid = 1'b1; st_addr = 32'h50; st_data = 32'h5; ld_addr = 32'h50;
    #1;
    check_eq("t4_same_cycle_invisible", 32'(ld_hit), 0);
    st_valid = 1'b0;
    tick();
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    clear_log();
    push(32'h20, 32'hAAAA);
    push(32'h20, 32'hBBBB);
    ld_addr = 32'h22;
    #1;
    check_eq("t4_hit", 32'(ld_hit), 1);
    check_eq("t4_fwd", ld_fwd_data, 32'hBBBB);
`ifdef DM_STORE_BUFFER_COALESCE_EN
    check_eq("t4_head_data", dm_wdata, 32'hBBBB);
`else
    check_eq("t4_head_data", dm_wdata, 32'hAAAA);
`endif
    ld_addr = 32'h24;
    #1;
    check_eq("t4_miss", 32'(ld_hit), 0);
    check_eq("t4_miss_data", ld_fwd_data, 0);
    ld_addr = 32'h20;
    dm_ready = 1'b1;
    #1;
    check_eq("t4_popping_fwd", 32'(ld_hit), 1);
    tick(); tick();
    dm_ready = 1'b0;
`ifdef DM_STORE_BUFFER_COALESCE_EN
    check_eq("t4_writes", 32'(wr_addr.size()), 1);
`else
    check_eq("t4_writes", 32'(wr_addr.size()), 2);
`endif
    check_eq("t4_empty", 32'(empty), 1);

    // 5: push+pop when full (push refused) and when count=2 (count holds)
    clear_log();
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(i * 4), 32'(i));
    st_valid = 1'b1; st_addr = 32'h70; st_data = 32'h77; dm_ready = 1'b1;
    tick();
    st_valid = 1'b0; dm_ready = 1'b0;
    check_eq("t5_room_after_pop", 32'(st_ready), 1);
    dm_ready = 1'b1;
    repeat (4) tick();
    dm_ready = 1'b0;
    check_eq("t5_full_writes", 32'(wr_addr.size()), 4);
    if (wr_addr.size() == 4) check_eq("t5_last_addr", wr_addr[3], 32'h6C);
    clear_log();
    push(32'h80, 32'h1); push(32'h84, 32'h2);
    st_valid = 1'b1; st_addr = 32'h88; st_data = 32'h3; dm_ready = 1'b1;
    tick();
    st_valid = 1'b0;
    tick();
    check_eq("t5_cnt2_not_empty", 32'(empty), 0);
    tick();
    dm_ready = 1'b0;
    check_eq("t5_cnt2_empty", 32'(empty), 1);
    check_eq("t5_cnt2_writes", 32'(wr_addr.size()), 3);
    if (wr_addr.size() == 3) check_eq("t5_cnt2_last", wr_addr[2], 32'h88);

`ifdef DM_STORE_BUFFER_COALESCE_EN
    // 6: coalescing into the youngest entry
    clear_log();
    push(32'h30, 32'h1);
    push(32'h30, 32'h2);
    dm_ready = 1'b1;
    tick();
    dm_ready = 1'b0;
    check_eq("t6_empty", 32'(empty), 1);
    check_eq("t6_writes", 32'(wr_addr.size()), 1);
    if (wr_data.size() == 1) check_eq("t6_data", wr_data[0], 32'h2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
